alu_requester: RTL and testbench

Command-side initiator for the iterative 32-bit ALU. It accepts one arithmetic command at a time over a valid/ready port and sequences the ALU's level-sensitive `operation`/`busy` interface. It captures the 64-bit result and returns it with tag and status over a valid/ready response port. It sits between the instruction/control logic and the ALU; the ALU sees only this block.

---
 rtl/alu_requester.sv | 173 +++++++++++++++++
 tb/tb_alu_requester.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_requester.sv
// Command-side initiator for the iterative 32-bit ALU: accepts one command at a time,
// sequences the ALU operation/busy handshake and returns the captured result with tag and status.
module alu_requester #(
   parameter int          TAG_W   = 4,
   parameter int          TIMEOUT = 48,
   parameter logic [2:0]  IDLE_OP = 3'b111
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [31:0]      cmd_a,
   input  logic [31:0]      cmd_b,
   input  logic [TAG_W-1:0] cmd_tag,
   output logic [31:0]      alu_operandA,
   output logic [31:0]      alu_operandB,
   output logic [2:0]       alu_operation,
   output logic             alu_operation_valid,
   input  logic             alu_busy,
   input  logic [63:0]      alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [63:0]      rsp_result,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_err,
   output logic             rsp_timeout
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_ADDCAP,
      S_HOLD,
      S_WAIT,
      S_RESP
   } state_t;

   state_t             state, state_d;
   logic [CNT_W-1:0]   wait_cnt, wait_cnt_d;
   logic [31:0]        opa_d, opb_d;
   logic [2:0]         op_d;
   logic               opv_d;
   logic               rsp_valid_d, rsp_err_d, rsp_timeout_d;
   logic [63:0]        rsp_result_d;
   logic [TAG_W-1:0]   rsp_tag_d;

   assign cmd_ready = (state == S_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state               <= S_IDLE;
         wait_cnt            <= '0;
         alu_operandA        <= '0;
         alu_operandB        <= '0;
         alu_operation       <= IDLE_OP;
         alu_operation_valid <= 1'b0;
         rsp_valid           <= 1'b0;
         rsp_result          <= '0;
         rsp_tag             <= '0;
         rsp_err             <= 1'b0;
         rsp_timeout         <= 1'b0;
      end else begin
         state               <= state_d;
         wait_cnt            <= wait_cnt_d;
         alu_operandA        <= opa_d;
         alu_operandB        <= opb_d;
         alu_operation       <= op_d;
         alu_operation_valid <= opv_d;
         rsp_valid           <= rsp_valid_d;
         rsp_result          <= rsp_result_d;
         rsp_tag             <= rsp_tag_d;
         rsp_err             <= rsp_err_d;
         rsp_timeout         <= rsp_timeout_d;
      end
   end

   // Outputs are registered: each branch sets the values seen in the *next* state.
   always_comb begin
      state_d       = state;
      wait_cnt_d    = wait_cnt;
      opa_d         = alu_operandA;
      opb_d         = alu_operandB;
      op_d          = alu_operation;
      opv_d         = alu_operation_valid;
      rsp_valid_d   = rsp_valid;
      rsp_result_d  = rsp_result;
      rsp_tag_d     = rsp_tag;
      rsp_err_d     = rsp_err;
      rsp_timeout_d = rsp_timeout;

      case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               rsp_tag_d     = cmd_tag;
               wait_cnt_d    = '0;
               rsp_timeout_d = 1'b0;
               if (cmd_op[2]) begin
                  rsp_err_d    = 1'b1;
                  rsp_result_d = '0;
                  rsp_valid_d  = 1'b1;
                  state_d      = S_RESP;
               end else begin
                  rsp_err_d = 1'b0;
                  op_d      = cmd_op;
                  opv_d     = 1'b1;
                  opa_d     = cmd_a;
                  opb_d     = cmd_b;
                  state_d   = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (alu_operation[1]) begin
               state_d = S_HOLD;
            end else begin
               op_d    = IDLE_OP;
               opv_d   = 1'b0;
               state_d = S_ADDCAP;
            end
         end
         S_ADDCAP: begin
            rsp_result_d = alu_result;
            rsp_valid_d  = 1'b1;
            opa_d        = '0;
            opb_d        = '0;
            state_d      = S_RESP;
         end
         S_HOLD: begin
            // Drop mul/div before the ALU can finish so it never restarts on completion.
            op_d  = IDLE_OP;
            opv_d = 1'b0;
            if (!alu_busy) begin
               rsp_timeout_d = 1'b1;
               rsp_result_d  = '0;
               rsp_valid_d   = 1'b1;
               opa_d         = '0;
               opb_d         = '0;
               state_d       = S_RESP;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            wait_cnt_d = wait_cnt + CNT_W'(1);
            if (!alu_busy) begin
               rsp_result_d = alu_result;
               rsp_valid_d  = 1'b1;
               opa_d        = '0;
               opb_d        = '0;
               state_d      = S_RESP;
            end else if (wait_cnt_d == CNT_W'(TIMEOUT)) begin
               rsp_timeout_d = 1'b1;
               rsp_result_d  = '0;
               rsp_valid_d   = 1'b1;
               opa_d         = '0;
               opb_d         = '0;
               state_d       = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_alu_requester.sv
// Directed bench for alu_requester with a behavioural iterative-ALU stand-in that can
// also be forced into busy-stuck-low / busy-stuck-high fault modes.
module tb_alu_requester;

   localparam logic [2:0] IDLE_OP = 3'b111;

   logic        clk, rst;
   logic        cmd_valid, cmd_ready;
   logic [2:0]  cmd_op;
   logic [31:0] cmd_a, cmd_b;
   logic [3:0]  cmd_tag;
   logic [31:0] alu_operandA, alu_operandB;
   logic [2:0]  alu_operation;
   logic        alu_operation_valid, alu_busy;
   logic [63:0] alu_result;
   logic        rsp_valid, rsp_ready;
   logic [63:0] rsp_result;
   logic [3:0]  rsp_tag;
   logic        rsp_err, rsp_timeout;

   int errors = 0;
   int checks = 0;
   int alu_mode = 0;
   int starts = 0;
   logic [2:0] op_log  [0:63];
   logic       opv_log [0:63];

   alu_requester #(.TAG_W(4), .TIMEOUT(48), .IDLE_OP(IDLE_OP)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
      .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
      .alu_operation(alu_operation), .alu_operation_valid(alu_operation_valid),
      .alu_busy(alu_busy), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_tag(rsp_tag), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU stand-in: add/sub registered in one cycle; mul/div busy for 34 cycles after start.
   logic        busy_r;
   logic [5:0]  alu_cnt;
   logic [63:0] res_r, pend, sa, sb;
   logic signed [31:0] a32, b32;
   assign sa = {{32{alu_operandA[31]}}, alu_operandA};
   assign sb = {{32{alu_operandB[31]}}, alu_operandB};
   assign a32 = alu_operandA;
   assign b32 = alu_operandB;
   assign alu_busy   = (alu_mode == 1) ? 1'b0 : (alu_mode == 2) ? 1'b1 : busy_r;
   assign alu_result = res_r;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_r <= 1'b0; alu_cnt <= '0; res_r <= '0; pend <= '0;
      end else if (alu_mode != 0) begin
         busy_r <= 1'b0;
      end else if (busy_r) begin
         if (alu_cnt == 0) begin
            busy_r <= 1'b0;
            res_r  <= pend;
         end else alu_cnt <= alu_cnt - 6'd1;
      end else begin
         case (alu_operation)
            3'b000: res_r <= sa + sb;
            3'b001: res_r <= sa - sb;
            3'b010: begin busy_r <= 1'b1; alu_cnt <= 6'd33; starts <= starts + 1; pend <= sa * sb; end
            3'b011: begin
               busy_r <= 1'b1; alu_cnt <= 6'd33; starts <= starts + 1;
               pend <= (b32 == 0) ? '1 : {32'(a32 % b32), 32'(a32 / b32)};
            end
            default: ;
         endcase
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_op = 3'b100; cmd_a = '1; cmd_b = '1; cmd_tag = '1;
   endtask

   task automatic wait_rsp(input int budget, output int lat);
      lat = -1;
      for (int n = 1; n <= budget; n++) begin
         @(negedge clk);
         op_log[n]  = alu_operation;
         opv_log[n] = alu_operation_valid;
         if (rsp_valid) begin
            lat = n;
            break;
         end
      end
      check("rsp_seen", {63'd0, rsp_valid}, 64'd1);
   endtask

   task automatic take();
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      int lat, bad, s0;
      rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check("rst_alu_op", {61'd0, alu_operation}, {61'd0, IDLE_OP});
      check("rst_op_valid", {63'd0, alu_operation_valid}, 64'd0);
      rst = 1'b1;

      // add 5+7
      send(3'b000, 32'd5, 32'd7, 4'd3);
      wait_rsp(10, lat);
      check("add_lat", 64'(lat), 64'd3);
      check("add_result", rsp_result, 64'd12);
      check("add_tag", {60'd0, rsp_tag}, 64'd3);
      check("add_flags", {62'd0, rsp_err, rsp_timeout}, 64'd0);
      check("add_issue_op", {61'd0, op_log[1]}, 64'd0);
      check("add_issue_valid", {63'd0, opv_log[1]}, 64'd1);
      check("add_cap_op", {61'd0, op_log[2]}, {61'd0, IDLE_OP});
      take();
      check("idle_ready", {63'd0, cmd_ready}, 64'd1);
      check("idle_operandA", {32'd0, alu_operandA}, 64'd0);

      // mul -3 x 7
      s0 = starts;
      send(3'b010, 32'hFFFF_FFFD, 32'd7, 4'd5);
      wait_rsp(60, lat);
      check("mul_lat", 64'(lat), 64'd37);
      check("mul_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFEB);
      check("mul_tag", {60'd0, rsp_tag}, 64'd5);
      bad = 0;
      for (int c = 1; c <= 36; c++) begin
         if (op_log[c] !== ((c <= 2) ? 3'b010 : IDLE_OP)) bad++;
         if (opv_log[c] !== (c <= 2)) bad++;
      end
      check("mul_op_trace", 64'(bad), 64'd0);
      check("mul_starts", 64'(starts - s0), 64'd1);
      take();

      // div -100 / 7, then back-to-back sub 3-10
      send(3'b011, 32'hFFFF_FF9C, 32'd7, 4'd6);
      wait_rsp(60, lat);
      check("div_lat", 64'(lat), 64'd37);
      check("div_result", rsp_result, 64'hFFFF_FFFE_FFFF_FFF2);
      take();
      check("b2b_ready", {63'd0, cmd_ready}, 64'd1);
      send(3'b001, 32'd3, 32'd10, 4'd7);
      wait_rsp(10, lat);
      check("sub_lat", 64'(lat), 64'd3);
      check("sub_result_lo", {32'd0, rsp_result[31:0]}, 64'h0000_0000_FFFF_FFF9);
      check("sub_tag", {60'd0, rsp_tag}, 64'd7);
      take();

      // unsupported opcode
      s0 = starts;
      send(3'b101, 32'd1, 32'd2, 4'd9);
      wait_rsp(10, lat);
      check("bad_lat", 64'(lat), 64'd1);
      check("bad_err", {63'd0, rsp_err}, 64'd1);
      check("bad_result", rsp_result, 64'd0);
      check("bad_tag", {60'd0, rsp_tag}, 64'd9);
      check("bad_alu_op", {61'd0, op_log[1]}, {61'd0, IDLE_OP});
      check("bad_starts", 64'(starts - s0), 64'd0);
      take();

      // busy stuck low on mul
      alu_mode = 1;
      send(3'b010, 32'd3, 32'd4, 4'hA);
      wait_rsp(10, lat);
      check("stuck0_lat", 64'(lat), 64'd3);
      check("stuck0_flags", {62'd0, rsp_err, rsp_timeout}, 64'd1);
      check("stuck0_result", rsp_result, 64'd0);
      take();

      // busy stuck high: 48 WAIT cycles (3..50) then response
      alu_mode = 2;
      send(3'b011, 32'd100, 32'd7, 4'hB);
      wait_rsp(63, lat);
      check("stuck1_lat", 64'(lat), 64'd51);
      check("stuck1_flags", {62'd0, rsp_err, rsp_timeout}, 64'd1);
      check("stuck1_result", rsp_result, 64'd0);
      take();
      alu_mode = 0;

      // response stall for 10 cycles
      send(3'b000, 32'h1234_5678, 32'd1, 4'hC);
      wait_rsp(10, lat);
      check("stall_lat", 64'(lat), 64'd3);
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_result !== 64'h1234_5679 || rsp_tag !== 4'hC ||
             rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || cmd_ready !== 1'b0 ||
             alu_operation !== IDLE_OP) bad++;
      end
      check("stall_stable", 64'(bad), 64'd0);
      take();

      // reset mid-mul
      send(3'b010, 32'd6, 32'd7, 4'hD);
      repeat (10) @(negedge clk);
      check("mid_busy_ready", {63'd0, cmd_ready}, 64'd0);
      rst = 1'b0;
      #1;
      check("arst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      check("arst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check("arst_rsp_tag", {60'd0, rsp_tag}, 64'd0);
      check("arst_operands", {alu_operandA, alu_operandB}, 64'd0);
      check("arst_alu_op", {61'd0, alu_operation}, {61'd0, IDLE_OP});
      check("arst_op_valid", {63'd0, alu_operation_valid}, 64'd0);
      check("arst_flags", {62'd0, rsp_err, rsp_timeout}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      send(3'b000, 32'd2, 32'd2, 4'd1);
      wait_rsp(10, lat);
      check("post_rst_lat", 64'(lat), 64'd3);
      check("post_rst_result", rsp_result, 64'd4);
      take();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
